dip_replacement_unit: RTL and testbench
=======================================

DIP_REPLACEMENT_UNIT -- requirements
Module: dip_replacement_unit

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; power of two, 2..16.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6: set index width; even, >=2; DEPTH = 2^INDEX_WIDTH.
REQ-003 SHALL have parameter PSEL_WIDTH, default 10: policy-select counter width.
REQ-004 SHALL have parameter BIP_LOG2, default 5: BIP throttle; one MRU insertion per 2^BIP_LOG2 BIP fills.
REQ-005 SHALL have parameter MODE, default MODE_DIP: one of MODE_LRU, MODE_LIP, MODE_BIP, MODE_DIP.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port lookup_valid, input, 1: a cache access occurs this cycle.
REQ-009 SHALL have port lookup_index, input, INDEX_WIDTH: set of the access.
REQ-010 SHALL have port lookup_hit, input, 1: the access hit.
REQ-011 SHALL have port lookup_way, input, clog2(WAYS): hitting way; ignored when lookup_hit=0.
REQ-012 SHALL have port valid_mask, input, WAYS: valid bits of set lookup_index.
REQ-013 SHALL have port fill_valid, input, 1: a line is installed this cycle.
REQ-014 SHALL have port fill_index, input, INDEX_WIDTH: set of the fill.
REQ-015 SHALL have port fill_way, input, clog2(WAYS): way of the fill.
REQ-016 SHALL have port victim_way, output, clog2(WAYS): replacement candidate for lookup_index.
REQ-017 SHALL have port follower_bip, output, 1: follower sets currently use BIP insertion.
REQ-018 SHALL have port psel, output, PSEL_WIDTH: current policy-select counter.

Function
REQ-019 SHALL hold WAYS-1 tree-PLRU bits per set; bit=0 points victim search at the lower half of its subtree, bit=1 at the upper half.
REQ-020 SHALL drive victim_way combinationally, zero latency: the lowest-numbered way with valid_mask=0 if any, else the way reached by following the tree bits of lookup_index.
REQ-021 SHALL, on lookup_valid & lookup_hit, promote lookup_way: every bit on its path points away from it; visible next cycle.
REQ-022 SHALL, on fill_valid, insert fill_way at MRU (promote) or LRU (every path bit points toward it), as set by the effective policy.
REQ-023 SHALL classify sets with K = INDEX_WIDTH/2: LRU leader if index[top K] == index[low K]; BIP leader if index[top K] == ~index[low K]; follower otherwise.
REQ-024 SHALL set the effective policy per MODE: LRU gives MRU insertion always; LIP gives LRU insertion always; BIP gives BIP always; DIP gives MRU insertion in LRU leaders, BIP in BIP leaders, and BIP in followers when follower_bip=1, else MRU insertion.
REQ-025 SHALL implement BIP as MRU insertion when bip_ctr==0, else LRU insertion; bip_ctr (BIP_LOG2 bits, wrapping) increments on every fill that uses BIP.
REQ-026 SHALL, in MODE_DIP, on lookup_valid & ~lookup_hit, increment psel for an LRU-leader miss and decrement it for a BIP-leader miss, saturating at all-ones and zero.
REQ-027 SHALL drive follower_bip = psel MSB in MODE_DIP and hold it 0 in the other modes; psel SHALL remain unchanged outside MODE_DIP.
REQ-028 SHALL, when a hit and a fill target the same index in one cycle, apply the fill only; on different indices, apply both.

Reset
REQ-029 SHALL, while rst=1, clear all tree bits, load psel to 2^(PSEL_WIDTH-1)-1 and bip_ctr to 0, with effect at the next edge.
REQ-030 SHALL let rst override any concurrent hit, miss or fill; such an update SHALL be lost.
REQ-031 SHALL, one cycle after reset, output victim_way=0 for a fully valid set, follower_bip=0 and psel=511 (default PSEL_WIDTH).

Structure
REQ-032 SHALL take the replacement_mode_e enum (MODE_LRU..MODE_DIP) from the shared mips_core_pkg.
REQ-033 SHALL place per-set tree logic in one combinational sub-module, plru_tree, that outputs the victim way, the promoted bits and the demoted bits for a given bit vector and way.

Verification (WAYS=4, INDEX_WIDTH=6, PSEL_WIDTH=10, BIP_LOG2=5)
REQ-034 SHALL cover reset: valid_mask=4'hF on any index -> victim_way=0, psel=511, follower_bip=0.
REQ-035 SHALL cover tree order: set 5 fully valid, hits on ways 0,1,2,3 -> victim_way=0; then a hit on way 0 -> victim_way=2.
REQ-036 SHALL cover the invalid-way override: valid_mask=4'b1011 -> victim_way=2 for any tree state.
REQ-037 SHALL cover set dueling in MODE_DIP: 600 misses to index 0 -> psel=1023, follower_bip=1; then 1100 misses to index 7 -> psel=0, follower_bip=0.
REQ-038 SHALL cover insertion in MODE_LIP: fill set 3 way 2 -> victim_way=2 next cycle. In MODE_BIP: the first fill inserts at MRU, the next 31 at LRU, the 33rd at MRU.
REQ-039 SHALL cover conflicts: same-cycle hit way 1 and fill way 1 on set 9 in MODE_LIP -> victim_way=1; rst asserted with a fill -> no update takes effect.

Source files
------------

// File: rtl/mips_core_pkg.sv
// ----------------------------------------------------------------------------
// mips_core_pkg
// Types shared across the MIPS core slice. The replacement unit picks its
// insertion behaviour from replacement_mode_e. set_class_e names the role a
// cache set plays while the unit is choosing between LRU and BIP insertion.
// No ports; this is a package.
// ----------------------------------------------------------------------------
package mips_core_pkg;

   // Insertion/replacement policy the replacement unit runs.
   typedef enum logic [1:0] {
      MODE_LRU = 2'd0,
      MODE_LIP = 2'd1,
      MODE_BIP = 2'd2,
      MODE_DIP = 2'd3
   } replacement_mode_e;

   // Role of a set during set dueling: a fixed LRU sample, a fixed BIP
   // sample, or a follower that uses whichever policy is currently winning.
   typedef enum logic [1:0] {
      SET_FOLLOWER   = 2'd0,
      SET_LRU_LEADER = 2'd1,
      SET_BIP_LEADER = 2'd2
   } set_class_e;

endpackage

// File: rtl/dip_replacement_unit_plru_tree.sv
// ----------------------------------------------------------------------------
// plru_tree
// Purely combinational tree-PLRU helper for one cache set.
// Bits are stored heap-style: node 0 is the root and node n has children
// 2n+1 (lower half) and 2n+2 (upper half). A bit of 0 steers the victim
// search into the lower half of its subtree, a 1 into the upper half.
// Ports:
//   treeBits     - current WAYS-1 tree bits of the set
//   way          - way to promote or demote
//   victimWay    - way reached by following treeBits from the root
//   promotedBits - treeBits with every bit on way's path pointing away from it
//   demotedBits  - treeBits with every bit on way's path pointing toward it
// ----------------------------------------------------------------------------
module plru_tree #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-2:0]         treeBits,
   input  logic [$clog2(WAYS)-1:0] way,
   output logic [$clog2(WAYS)-1:0] victimWay,
   output logic [WAYS-2:0]         promotedBits,
   output logic [WAYS-2:0]         demotedBits
);

   localparam int LEVELS    = $clog2(WAYS);
   localparam int NODE_BITS = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

   // The node visited at a given level is the first node of that level plus
   // the way-number bits already chosen above it.
   function automatic logic [NODE_BITS-1:0] nodeIndex(input int lvl,
                                                      input logic [LEVELS-1:0] w);
      return NODE_BITS'((1 << lvl) - 1) + NODE_BITS'(w >> (LEVELS - lvl));
   endfunction

   // Walk from the root to a leaf. Each level's bit becomes the next
   // way-number bit, so the partially built victimWay also names the next
   // node to visit.
   always_comb begin
      victimWay = '0;
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         victimWay[LEVELS-1-lvl] = treeBits[nodeIndex(lvl, victimWay)];
      end
   end

   // Rewrite only the bits on the path to 'way'. Promotion steers each bit
   // toward the sibling half (away from way); demotion steers it toward way so
   // that way becomes the next victim of the set.
   always_comb begin
      promotedBits = treeBits;
      demotedBits  = treeBits;
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         promotedBits[nodeIndex(lvl, way)] = ~way[LEVELS-1-lvl];
         demotedBits[nodeIndex(lvl, way)]  = way[LEVELS-1-lvl];
      end
   end

endmodule

// File: rtl/dip_replacement_unit.sv
// ----------------------------------------------------------------------------
// dip_replacement_unit
// Tree-PLRU replacement state for a set-associative cache, with selectable
// insertion policy (LRU, LIP, BIP or dynamic DIP set dueling).
// Ports:
//   clk, rst                 - clock; synchronous active-high reset
//   lookup_valid/index/hit   - an access to set lookup_index and whether it hit
//   lookup_way               - hitting way (promoted to MRU on a hit)
//   valid_mask               - valid bits of set lookup_index
//   fill_valid/index/way     - a line installed into fill_way of set fill_index
//   victim_way               - replacement candidate for lookup_index (combinational)
//   follower_bip             - follower sets currently insert with BIP
//   psel                     - policy-select counter
// ----------------------------------------------------------------------------
module dip_replacement_unit
   import mips_core_pkg::*;
#(
   parameter int                WAYS        = 4,
   parameter int                INDEX_WIDTH = 6,
   parameter int                PSEL_WIDTH  = 10,
   parameter int                BIP_LOG2    = 5,
   parameter replacement_mode_e MODE        = MODE_DIP
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      lookup_valid,
   input  logic [INDEX_WIDTH-1:0]    lookup_index,
   input  logic                      lookup_hit,
   input  logic [$clog2(WAYS)-1:0]   lookup_way,
   input  logic [WAYS-1:0]           valid_mask,
   input  logic                      fill_valid,
   input  logic [INDEX_WIDTH-1:0]    fill_index,
   input  logic [$clog2(WAYS)-1:0]   fill_way,
   output logic [$clog2(WAYS)-1:0]   victim_way,
   output logic                      follower_bip,
   output logic [PSEL_WIDTH-1:0]     psel
);

   localparam int WAY_BITS  = $clog2(WAYS);
   localparam int TREE_BITS = WAYS - 1;
   localparam int DEPTH     = 1 << INDEX_WIDTH;
   localparam int HALF      = INDEX_WIDTH / 2;
   localparam logic [PSEL_WIDTH-1:0] PSEL_INIT = {1'b0, {(PSEL_WIDTH-1){1'b1}}};

   logic [TREE_BITS-1:0] treeMem [DEPTH];
   logic [TREE_BITS-1:0] lookupBits;
   logic [TREE_BITS-1:0] lookupPromoted;
   logic [TREE_BITS-1:0] unusedLookupDemoted;
   logic [TREE_BITS-1:0] fillBits;
   logic [TREE_BITS-1:0] fillPromoted;
   logic [TREE_BITS-1:0] fillDemoted;
   logic [TREE_BITS-1:0] fillNewBits;
   logic [WAY_BITS-1:0]  treeVictim;
   logic [WAY_BITS-1:0]  unusedFillVictim;
   logic [BIP_LOG2-1:0]  bipCtr;
   logic                 fillUsesBip;
   logic                 fillAtMru;
   logic                 hitIsShadowed;
   set_class_e           fillClass;
   set_class_e           lookupClass;

   // Leader sets are picked by comparing the upper and lower halves of the
   // index: equal halves sample LRU, complementary halves sample BIP, so the
   // two leader groups never overlap and are spread evenly over the cache.
   function automatic set_class_e classifySet(input logic [INDEX_WIDTH-1:0] idx);
      logic [HALF-1:0] upperHalf;
      logic [HALF-1:0] lowerHalf;
      upperHalf = idx[INDEX_WIDTH-1 -: HALF];
      lowerHalf = idx[HALF-1:0];
      if (upperHalf == lowerHalf) begin
         return SET_LRU_LEADER;
      end else if (upperHalf == ~lowerHalf) begin
         return SET_BIP_LEADER;
      end else begin
         return SET_FOLLOWER;
      end
   endfunction

   assign lookupBits  = treeMem[lookup_index];
   assign fillBits    = treeMem[fill_index];
   assign lookupClass = classifySet(lookup_index);
   assign fillClass   = classifySet(fill_index);

   plru_tree #(.WAYS(WAYS)) lookupTree (
      .treeBits     (lookupBits),
      .way          (lookup_way),
      .victimWay    (treeVictim),
      .promotedBits (lookupPromoted),
      .demotedBits  (unusedLookupDemoted)
   );

   plru_tree #(.WAYS(WAYS)) fillTree (
      .treeBits     (fillBits),
      .way          (fill_way),
      .victimWay    (unusedFillVictim),
      .promotedBits (fillPromoted),
      .demotedBits  (fillDemoted)
   );

   // An empty way always beats the tree: scanning from the top down leaves
   // the lowest-numbered invalid way as the final choice.
   always_comb begin
      victim_way = treeVictim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_mask[w]) begin
            victim_way = WAY_BITS'(w);
         end
      end
   end

   // Decide where the incoming line lands. BIP mostly inserts at LRU and
   // only lets one fill in every 2^BIP_LOG2 through at MRU, which protects
   // the cache from streaming data. In DIP mode the leaders keep their fixed
   // policy and the followers track the winning policy through follower_bip.
   always_comb begin
      fillUsesBip = 1'b0;
      fillAtMru   = 1'b1;
      case (MODE)
         MODE_LRU: fillAtMru = 1'b1;
         MODE_LIP: fillAtMru = 1'b0;
         MODE_BIP: fillUsesBip = 1'b1;
         MODE_DIP: begin
            case (fillClass)
               SET_LRU_LEADER: fillUsesBip = 1'b0;
               SET_BIP_LEADER: fillUsesBip = 1'b1;
               default:        fillUsesBip = follower_bip;
            endcase
         end
         default: fillAtMru = 1'b1;
      endcase
      if (fillUsesBip) begin
         fillAtMru = (bipCtr == '0);
      end
   end

   assign fillNewBits   = fillAtMru ? fillPromoted : fillDemoted;
   assign hitIsShadowed = fill_valid && (fill_index == lookup_index);
   assign follower_bip  = (MODE == MODE_DIP) ? psel[PSEL_WIDTH-1] : 1'b0;

   // Tree state update. A hit and a fill on the same set collide on one
   // entry; the fill carries the newer information, so the hit is dropped.
   // Reset wins over both and clears every set back to "victim is way 0".
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            treeMem[s] <= '0;
         end
      end else begin
         if (lookup_valid && lookup_hit && !hitIsShadowed) begin
            treeMem[lookup_index] <= lookupPromoted;
         end
         if (fill_valid) begin
            treeMem[fill_index] <= fillNewBits;
         end
      end
   end

   // Policy bookkeeping. The BIP throttle advances on every fill that used
   // BIP. psel counts leader misses: LRU-leader misses push it up (LRU is
   // losing, favour BIP) and BIP-leader misses pull it down, saturating at
   // both ends. It starts just below the midpoint so followers begin on LRU.
   always_ff @(posedge clk) begin
      if (rst) begin
         psel   <= PSEL_INIT;
         bipCtr <= '0;
      end else begin
         if (fill_valid && fillUsesBip) begin
            bipCtr <= bipCtr + BIP_LOG2'(1);
         end
         if ((MODE == MODE_DIP) && lookup_valid && !lookup_hit) begin
            if ((lookupClass == SET_LRU_LEADER) && (psel != '1)) begin
               psel <= psel + PSEL_WIDTH'(1);
            end else if ((lookupClass == SET_BIP_LEADER) && (psel != '0)) begin
               psel <= psel - PSEL_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_dip_replacement_unit.sv
// ----------------------------------------------------------------------------
// tb_dip_replacement_unit
// Drives three copies of the replacement unit (DIP, LIP and BIP modes) with
// the same inputs. The reference model keeps, per internal tree node, which
// half of the ways was touched more recently, and derives victims by range
// halving; psel and the BIP throttle are plain saturating/modular integers.
// ----------------------------------------------------------------------------
module tb_dip_replacement_unit;
   import mips_core_pkg::*;

   typedef struct packed {
      logic [1:0] dut;
      logic [1:0] victim;
      logic [9:0] psel;
      logic       fbip;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       lookupValid;
   logic [5:0] lookupIndex;
   logic       lookupHit;
   logic [1:0] lookupWay;
   logic [3:0] validMask;
   logic       fillValid;
   logic [5:0] fillIndex;
   logic [1:0] fillWay;

   logic [1:0] victimDip, victimLip, victimBip;
   logic       fbipDip, fbipLip, fbipBip;
   logic [9:0] pselDip, pselLip, pselBip;

   exp_t  expQ[$];
   string tagQ[$];
   string dutNames [3] = '{"dip", "lip", "bip"};

   bit recentUpper [3][64][3];
   int pselModel;
   int bipCtrModel [3];

   int checks = 0;
   int errors = 0;

   exp_t  monEntry;
   string monTag;
   int    actV, actP, actF;

   always #5 clk = ~clk;

   dip_replacement_unit #(.WAYS(4), .INDEX_WIDTH(6), .PSEL_WIDTH(10), .BIP_LOG2(5), .MODE(MODE_DIP)) dutDip (
      .clk(clk), .rst(rst), .lookup_valid(lookupValid), .lookup_index(lookupIndex),
      .lookup_hit(lookupHit), .lookup_way(lookupWay), .valid_mask(validMask),
      .fill_valid(fillValid), .fill_index(fillIndex), .fill_way(fillWay),
      .victim_way(victimDip), .follower_bip(fbipDip), .psel(pselDip));

   dip_replacement_unit #(.WAYS(4), .INDEX_WIDTH(6), .PSEL_WIDTH(10), .BIP_LOG2(5), .MODE(MODE_LIP)) dutLip (
      .clk(clk), .rst(rst), .lookup_valid(lookupValid), .lookup_index(lookupIndex),
      .lookup_hit(lookupHit), .lookup_way(lookupWay), .valid_mask(validMask),
      .fill_valid(fillValid), .fill_index(fillIndex), .fill_way(fillWay),
      .victim_way(victimLip), .follower_bip(fbipLip), .psel(pselLip));

   dip_replacement_unit #(.WAYS(4), .INDEX_WIDTH(6), .PSEL_WIDTH(10), .BIP_LOG2(5), .MODE(MODE_BIP)) dutBip (
      .clk(clk), .rst(rst), .lookup_valid(lookupValid), .lookup_index(lookupIndex),
      .lookup_hit(lookupHit), .lookup_way(lookupWay), .valid_mask(validMask),
      .fill_valid(fillValid), .fill_index(fillIndex), .fill_way(fillWay),
      .victim_way(victimBip), .follower_bip(fbipBip), .psel(pselBip));

   // Model: 0 = follower, 1 = LRU leader, 2 = BIP leader.
   function automatic int classOf(input int idx);
      if (idx / 8 == idx % 8) return 1;
      if (idx / 8 == 7 - (idx % 8)) return 2;
      return 0;
   endfunction

   task automatic modelReset();
      for (int m = 0; m < 3; m++) begin
         bipCtrModel[m] = 0;
         for (int s = 0; s < 64; s++) begin
            for (int n = 0; n < 3; n++) recentUpper[m][s][n] = 1'b1;
         end
      end
      pselModel = 511;
   endtask

   // The victim lives in the half that was NOT touched more recently.
   function automatic int modelVictim(input int m, input int set, input logic [3:0] mask);
      int node, lo, size, result;
      bit found;
      found = 1'b0;
      result = 0;
      for (int w = 0; w < 4; w++) begin
         if (!found && !mask[w]) begin
            found = 1'b1;
            result = w;
         end
      end
      if (!found) begin
         node = 0; lo = 0; size = 4;
         while (size > 1) begin
            if (recentUpper[m][set][node]) begin
               node = 2 * node + 1;
            end else begin
               lo = lo + size / 2;
               node = 2 * node + 2;
            end
            size = size / 2;
         end
         result = lo;
      end
      return result;
   endfunction

   // mru=1 marks way's half as recent at every level; mru=0 marks the other half.
   task automatic modelTouch(input int m, input int set, input int way, input bit mru);
      int node, lo, size;
      bit upper;
      node = 0; lo = 0; size = 4;
      while (size > 1) begin
         upper = (way >= lo + size / 2);
         recentUpper[m][set][node] = mru ? upper : !upper;
         if (upper) begin
            lo = lo + size / 2;
            node = 2 * node + 2;
         end else begin
            node = 2 * node + 1;
         end
         size = size / 2;
      end
   endtask

   function automatic bit modelFillMru(input int m, input int idx);
      bit useBip, mru;
      useBip = 1'b0;
      mru = 1'b1;
      if (m == 1) mru = 1'b0;
      else if (m == 2) useBip = 1'b1;
      else if (classOf(idx) == 2 || (classOf(idx) == 0 && pselModel >= 512)) useBip = 1'b1;
      if (useBip) begin
         mru = (bipCtrModel[m] == 0);
         bipCtrModel[m] = (bipCtrModel[m] + 1) % 32;
      end
      return mru;
   endfunction

   task automatic modelUpdate(input bit lv, input int li, input bit lh, input int lw,
                              input bit fv, input int fi, input int fw, input bit r);
      if (r) begin
         modelReset();
      end else begin
         for (int m = 0; m < 3; m++) begin
            if (fv) modelTouch(m, fi, fw, modelFillMru(m, fi));
            if (lv && lh && !(fv && fi == li)) modelTouch(m, li, lw, 1'b1);
         end
         if (lv && !lh) begin
            if (classOf(li) == 1 && pselModel < 1023) pselModel = pselModel + 1;
            if (classOf(li) == 2 && pselModel > 0) pselModel = pselModel - 1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Drive one cycle; if requested, queue the outputs the model expects while
   // these inputs are applied, then advance the model across the edge.
   task automatic applyStimulus(input string tag, input bit lv, input int li, input bit lh,
                                input int lw, input logic [3:0] vm, input bit fv,
                                input int fi, input int fw, input bit r, input bit doCheck);
      exp_t e;
      rst = r;
      lookupValid = lv; lookupIndex = 6'(li); lookupHit = lh; lookupWay = 2'(lw);
      validMask = vm;
      fillValid = fv; fillIndex = 6'(fi); fillWay = 2'(fw);
      if (doCheck) begin
         for (int m = 0; m < 3; m++) begin
            e.dut = 2'(m);
            e.victim = 2'(modelVictim(m, li, vm));
            e.psel = (m == 0) ? 10'(pselModel) : 10'd511;
            e.fbip = (m == 0) && (pselModel >= 512);
            expQ.push_back(e);
            tagQ.push_back(tag);
         end
      end
      @(posedge clk);
      modelUpdate(lv, li, lh, lw, fv, fi, fw, r);
      #1;
   endtask

   // Monitor: compares every queued expectation against the DUT at the
   // falling edge, well away from the active edge.
   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         monEntry = expQ.pop_front();
         monTag = tagQ.pop_front();
         case (monEntry.dut)
            2'd0: begin actV = victimDip; actP = pselDip; actF = fbipDip; end
            2'd1: begin actV = victimLip; actP = pselLip; actF = fbipLip; end
            default: begin actV = victimBip; actP = pselBip; actF = fbipBip; end
         endcase
         checkOutput($sformatf("%s.%s.victim", monTag, dutNames[monEntry.dut]), actV, int'(monEntry.victim));
         checkOutput($sformatf("%s.%s.psel", monTag, dutNames[monEntry.dut]), actP, int'(monEntry.psel));
         checkOutput($sformatf("%s.%s.fbip", monTag, dutNames[monEntry.dut]), actF, int'(monEntry.fbip));
      end
   end

   initial begin
      int leaders [16] = '{0, 9, 18, 27, 36, 45, 54, 63, 7, 14, 21, 28, 35, 42, 49, 56};
      int li, fi;
      logic [3:0] vm;
      modelReset();

      $display("[TB] reset, with a fill that must be lost");
      applyStimulus("reset0", 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0);
      applyStimulus("resetFill", 1, 3, 1, 3, 4'hF, 1, 3, 3, 1, 1);
      applyStimulus("postReset3", 0, 3, 0, 0, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("postResetAny", 0, int'($urandom_range(0, 63)), 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] tree order on set 5");
      for (int w = 0; w < 4; w++) applyStimulus("treeHit", 1, 5, 1, w, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("treeOrder", 0, 5, 0, 0, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("treeHit0", 1, 5, 1, 0, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("treeAfterHit0", 0, 5, 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] invalid-way override");
      applyStimulus("invalidSet5", 0, 5, 0, 0, 4'b1011, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++)
         applyStimulus("invalidWay", 0, int'($urandom_range(0, 63)), 0, 0, 4'b1011, 0, 0, 0, 0, 1);

      $display("[TB] BIP throttle: 34 fills of way 1 into set 20");
      for (int i = 0; i < 34; i++) applyStimulus("bipFill", 0, 20, 0, 0, 4'hF, 1, 20, 1, 0, 1);
      applyStimulus("bipAfter", 0, 20, 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] LIP insertion on set 3");
      applyStimulus("lipFill", 0, 3, 0, 0, 4'hF, 1, 3, 2, 0, 1);
      applyStimulus("lipVictim", 0, 3, 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] same-set hit and fill on set 9");
      applyStimulus("conflict", 1, 9, 1, 1, 4'hF, 1, 9, 1, 0, 1);
      applyStimulus("conflictVictim", 0, 9, 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] set dueling");
      for (int i = 0; i < 600; i++) applyStimulus("duelLru", 1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("duelLruDone", 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus("followerBipFill", 0, 3, 0, 0, 4'hF, 1, 3, i, 0, 1);
      for (int i = 0; i < 1100; i++) applyStimulus("duelBip", 1, 7, 0, 0, 4'hF, 0, 0, 0, 0, 1);
      applyStimulus("duelBipDone", 0, 7, 0, 0, 4'hF, 0, 0, 0, 0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 500; i++) begin
         li = ($urandom_range(0, 2) == 0) ? leaders[$urandom_range(0, 15)] : int'($urandom_range(0, 63));
         fi = ($urandom_range(0, 3) == 0) ? li : int'($urandom_range(0, 63));
         vm = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         applyStimulus("random", bit'($urandom_range(0, 1)), li, bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), vm, bit'($urandom_range(0, 1)), fi,
                       int'($urandom_range(0, 3)), ($urandom_range(0, 99) == 0), 1);
      end

      applyStimulus("idle", 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      checkOutput("drainQueue", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
